// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-style datapath: sequences fetch, decode and
// per-class execute states, drives datapath strobes and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t      state_r;
    state_t      next_s;
    logic [31:0] count_r;

    assign state       = state_r;
    assign instr_count = count_r;

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 32'd0;
        end else if (instr_done) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Next-state and datapath controls; everything is held low while reset is asserted,
    // which also keeps the FETCH strobes (tied to mem_ready) quiet during reset.
    always_comb begin
        next_s        = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (reset) begin
            case (state_r)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    next_s    = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: next_s = S_MEMADR;
                        OP_RTYPE:     next_s = S_EXEC;
                        OP_BEQ:       next_s = S_BRANCH;
                        OP_J:         next_s = S_JUMP;
                        OP_ADDI:      next_s = S_ADDIEX;
                        default: begin
                            next_s     = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_SW) begin
                        next_s = S_MEMWR;
                    end else begin
                        next_s = S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    next_s   = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                    next_s     = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    next_s    = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    next_s    = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                    next_s = S_FETCH;
                end
            endcase
        end else begin
            next_s = S_FETCH;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Port: clk, input, 1 bit; all state updates on the rising edge.
REQ-003 Port: reset, input, 1 bit; asynchronous, active-low (0 = reset).
REQ-004 Port: opcode, input, 6 bits; instruction[31:26] from the instruction register, stable from DECODE onward.
REQ-005 Port: mem_ready, input, 1 bit; memory access completes in the cycle it is high.
REQ-006 Ports: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a; outputs, 1 bit each; datapath strobes and selects.
REQ-007 Ports: alu_src_b, alu_op, pc_source; outputs, 2 bits each.
REQ-008 Port: state, output, 4 bits; current state encoding, for debug.
REQ-009 Ports: instr_done and illegal_op; outputs, 1 bit each; single-cycle pulses.
REQ-010 Port: instr_count, output, 32 bits; count of retired instructions.

Function
REQ-011 State encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 Codes 12-15 SHALL be treated as unreachable; if entered, the FSM goes to FETCH on the next edge.
REQ-013 Every output not listed for a state SHALL be 0 in that state.
REQ-014 FETCH SHALL drive: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-015 In FETCH, ir_write and pc_write SHALL equal mem_ready.
REQ-016 The FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE when it is 1.
REQ-017 DECODE SHALL drive: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-018 The DECODE next state SHALL be:
- 100011 (lw) or 101011 (sw): MEMADR
- 000000 (R-type): EXEC
- 000100 (beq): BRANCH
- 000010 (j): JUMP
- 001000 (addi): ADDIEX
- any other opcode: FETCH, with illegal_op=1 for that DECODE cycle.
REQ-019 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEMRD for lw or MEMWR for sw.
REQ-020 MEMRD SHALL drive mem_read=1, i_or_d=1; it holds until mem_ready=1, then goes to MEMWB.
REQ-021 MEMWB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1, then go to FETCH.
REQ-022 MEMWR SHALL drive mem_write=1, i_or_d=1; it holds until mem_ready=1, then goes to FETCH.
REQ-023 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB.
REQ-024 ALUWB SHALL drive reg_dst=1, mem_to_reg=0, reg_write=1, then go to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-026 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-027 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to ADDIWB.
REQ-028 ADDIWB SHALL drive reg_dst=0, mem_to_reg=0, reg_write=1, then go to FETCH.
REQ-029 instr_done SHALL be 1 for exactly the cycle in which the FSM leaves MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, JUMP or ADDIWB for FETCH.
REQ-030 instr_count SHALL increment by 1 on each edge where instr_done=1.
REQ-031 instr_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 Illegal opcodes SHALL NOT count as retired.
REQ-033 Instruction latency with mem_ready held at 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, counted from FETCH entry to the next FETCH entry.
REQ-034 Each wait cycle with mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle to that latency.
REQ-035 mem_ready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-036 While reset=0, the FSM SHALL be forced asynchronously to FETCH and instr_count to 0, independent of clk.
REQ-037 While reset=0, all strobes (pc_write, ir_write, reg_write, mem_write, pc_write_cond, instr_done, illegal_op) SHALL be 0.
REQ-038 An assertion of reset in any state, including mid-MEMWR, SHALL abort the instruction with no further write strobe.
REQ-039 After reset deasserts, the first fetch SHALL begin on the next rising edge with mem_ready sampled.

Verification
REQ-040 Reset, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; instr_count=1.
REQ-041 sw (101011) with mem_ready low for 3 cycles in MEMWR -> mem_write high for 4 cycles; instr_done pulses once; latency is 7 cycles.
REQ-042 Sequence R-type, addi, beq, j -> states 0,1,6,7; 0,1,10,11; 0,1,8; 0,1,9; pc_source=01 in BRANCH and 10 in JUMP; instr_count=4.
REQ-043 opcode=111111 -> states 0,1,0; illegal_op pulses once; instr_count unchanged.
REQ-044 Assert reset mid-MEMRD with mem_ready=0 -> state=0 immediately without waiting for clk; instr_count=0; no reg_write pulse.
REQ-045 Preload instr_count=0xFFFFFFFF via 2^32 retirements, or by forcing the counter -> one more j gives instr_count=0.
